// File: rtl/corner_tracker.sv
// Tracks the four corners of a marker-bounded region over each video frame.
// Ports: clk/reset, VGA_X/VGA_Y/pixel_valid/is_marker pixel stream,
// frame_start/frame_end strobes; outputs smoothed corner coordinates,
// corners_valid, update_pulse and marker_count.
module corner_tracker #(
    parameter int p_screen_width  = 640,
    parameter int p_screen_height = 480,
    parameter int p_min_count     = 64,
    parameter int p_smooth_shift  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] VGA_X,
    input  logic [10:0] VGA_Y,
    input  logic        pixel_valid,
    input  logic        is_marker,
    input  logic        frame_start,
    input  logic        frame_end,
    output logic [10:0] top_left_x,
    output logic [10:0] top_left_y,
    output logic [10:0] top_right_x,
    output logic [10:0] top_right_y,
    output logic [10:0] bot_left_x,
    output logic [10:0] bot_left_y,
    output logic [10:0] bot_right_x,
    output logic [10:0] bot_right_y,
    output logic        corners_valid,
    output logic        update_pulse,
    output logic [18:0] marker_count
);

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_e;

    localparam logic [10:0] W_LIM   = 11'(p_screen_width);
    localparam logic [10:0] H_LIM   = 11'(p_screen_height);
    localparam logic [18:0] MIN_CNT = 19'(p_min_count);

    state_e state_q, state_d;

    // Corner slots: 0 tl_x, 1 tl_y, 2 tr_x, 3 tr_y, 4 bl_x, 5 bl_y, 6 br_x, 7 br_y
    logic [7:0][10:0] raw_q, raw_d;
    logic [7:0][10:0] out_q, out_d;

    logic [18:0]        cnt_q, cnt_d;
    logic [3:0]         mv_q, mv_d;
    logic [11:0]        tl_m_q, tl_m_d, br_m_q, br_m_d;
    logic signed [11:0] tr_m_q, tr_m_d, bl_m_q, bl_m_d;

    logic        cv_q, cv_d;
    logic        pulse_q, pulse_d;
    logic [18:0] mc_q, mc_d;

    logic [11:0]        sum;
    logic signed [11:0] dif;
    logic               acc;
    logic               clr;

    // Signed 12-bit step toward raw, truncated back to 11 bits.
    function automatic logic [10:0] smooth(input logic [10:0] cur,
                                           input logic [10:0] raw);
        logic signed [11:0] diff;
        logic signed [11:0] stp;
        logic [11:0]        res;
        diff = $signed({1'b0, raw}) - $signed({1'b0, cur});
        stp  = diff >>> p_smooth_shift;
        res  = {1'b0, cur} + stp;
        return res[10:0];
    endfunction

    assign sum = {1'b0, VGA_X} + {1'b0, VGA_Y};
    assign dif = $signed({1'b0, VGA_X}) - $signed({1'b0, VGA_Y});

    assign acc = (state_q == SCAN) && pixel_valid && is_marker &&
                 (VGA_X < W_LIM) && (VGA_Y < H_LIM);

    // A frame_start that coincides with frame_end in SCAN is dropped.
    assign clr = frame_start &&
                 ((state_q == IDLE) || ((state_q == SCAN) && !frame_end));

    // State and all registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            raw_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            mv_q    <= '0;
            tl_m_q  <= '0;
            br_m_q  <= '0;
            tr_m_q  <= '0;
            bl_m_q  <= '0;
            cv_q    <= 1'b0;
            pulse_q <= 1'b0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            mv_q    <= mv_d;
            tl_m_q  <= tl_m_d;
            br_m_q  <= br_m_d;
            tr_m_q  <= tr_m_d;
            bl_m_q  <= bl_m_d;
            cv_q    <= cv_d;
            pulse_q <= pulse_d;
            mc_q    <= mc_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start) state_d = SCAN;
            SCAN:    if (frame_end) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulators: a restart clears first, so a pixel on that cycle
    // becomes the first pixel of the new frame.
    always_comb begin
        cnt_d  = cnt_q;
        mv_d   = mv_q;
        raw_d  = raw_q;
        tl_m_d = tl_m_q;
        br_m_d = br_m_q;
        tr_m_d = tr_m_q;
        bl_m_d = bl_m_q;
        if (clr) begin
            cnt_d = '0;
            mv_d  = '0;
        end
        if (acc) begin
            if (cnt_d != '1) cnt_d = cnt_d + 19'd1;
            if (!mv_d[0] || sum < tl_m_q) begin
                mv_d[0]  = 1'b1;
                tl_m_d   = sum;
                raw_d[0] = VGA_X;
                raw_d[1] = VGA_Y;
            end
            if (!mv_d[1] || dif > tr_m_q) begin
                mv_d[1]  = 1'b1;
                tr_m_d   = dif;
                raw_d[2] = VGA_X;
                raw_d[3] = VGA_Y;
            end
            if (!mv_d[2] || dif < bl_m_q) begin
                mv_d[2]  = 1'b1;
                bl_m_d   = dif;
                raw_d[4] = VGA_X;
                raw_d[5] = VGA_Y;
            end
            if (!mv_d[3] || sum > br_m_q) begin
                mv_d[3]  = 1'b1;
                br_m_d   = sum;
                raw_d[6] = VGA_X;
                raw_d[7] = VGA_Y;
            end
        end
    end

    // Outputs
    always_comb begin
        out_d   = out_q;
        cv_d    = cv_q;
        mc_d    = mc_q;
        pulse_d = 1'b0;
        if (state_q == UPDATE) begin
            pulse_d = 1'b1;
            mc_d    = cnt_q;
            if (cnt_q >= MIN_CNT) begin
                cv_d = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    out_d[i] = cv_q ? smooth(out_q[i], raw_q[i]) : raw_q[i];
                end
            end else begin
                cv_d = 1'b0;
            end
        end
    end

    assign top_left_x    = out_q[0];
    assign top_left_y    = out_q[1];
    assign top_right_x   = out_q[2];
    assign top_right_y   = out_q[3];
    assign bot_left_x    = out_q[4];
    assign bot_left_y    = out_q[5];
    assign bot_right_x   = out_q[6];
    assign bot_right_y   = out_q[7];
    assign corners_valid = cv_q;
    assign update_pulse  = pulse_q;
    assign marker_count  = mc_q;

endmodule

// File: doc/corner_tracker.md
CORNER_TRACKER -- requirements
Module: corner_tracker

Interface
REQ-001 Parameter p_screen_width, default 640, active pixel columns.
REQ-002 Parameter p_screen_height, default 480, active pixel rows.
REQ-003 Parameter p_min_count, default 64, minimum marker pixels for a valid frame.
REQ-004 Parameter p_smooth_shift, default 2, IIR smoothing shift; 0 means no smoothing.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
REQ-006 Data ports SHALL be:
- VGA_X  input  11  pixel column, unsigned.
- VGA_Y  input  11  pixel row, unsigned.
- pixel_valid  input  1  VGA_X/VGA_Y/is_marker valid this cycle.
- is_marker  input  1  pixel classified as boundary marker.
- frame_start  input  1  one-cycle pulse, start of frame.
- frame_end  input  1  one-cycle pulse, end of frame.
- top_left_x, top_left_y, top_right_x, top_right_y, bot_left_x, bot_left_y, bot_right_x, bot_right_y  output  11 each  smoothed corners, unsigned.
- corners_valid  output  1  corner outputs reflect a valid frame.
- update_pulse  output  1  one-cycle strobe after each frame evaluation.
- marker_count  output  19  accepted marker count of last evaluated frame.

Function
REQ-007 FSM SHALL have states IDLE, SCAN, UPDATE; reset state IDLE.
REQ-008 IDLE->SCAN on frame_start; SCAN->UPDATE on frame_end; UPDATE->IDLE unconditionally after one cycle.
REQ-009 Entering SCAN (from IDLE or via frame_start while in SCAN) SHALL clear the accumulators: running count 0, all four metric-valid flags 0.
REQ-010 frame_start and frame_end in the same SCAN cycle: frame_end SHALL win (go to UPDATE); frame_start ignored.
REQ-011 Pixel accepted only in SCAN with pixel_valid=1, is_marker=1, VGA_X<p_screen_width, VGA_Y<p_screen_height; pixel on the frame_end cycle is accepted.
REQ-012 Running count SHALL increment per accepted pixel, saturating at 2^19-1.
REQ-013 Metrics: TL = min(x+y), BR = max(x+y), TR = max(x-y), BL = min(x-y); x+y as 12-bit unsigned, x-y as 12-bit signed.
REQ-014 Per metric, store the value and its (x,y); replace only on strict improvement or when the metric-valid flag is 0; ties keep the earliest pixel.
REQ-015 In UPDATE with count >= p_min_count and corners_valid=0: outputs SHALL load the raw stored corners; corners_valid set to 1.
REQ-016 In UPDATE with count >= p_min_count and corners_valid=1: each coordinate out <= out + ((raw - out) >>> p_smooth_shift), computed 12-bit signed, arithmetic shift, result truncated to 11 bits.
REQ-017 In UPDATE with count < p_min_count: corner outputs held; corners_valid cleared to 0.
REQ-018 marker_count SHALL load the running count in every UPDATE.
REQ-019 Latency: frame_end sampled at edge k; outputs, corners_valid, marker_count change at edge k+1; update_pulse high exactly cycle k+1..k+2.
REQ-020 Inputs in IDLE and UPDATE SHALL be ignored except frame_start in IDLE.

Reset
REQ-021 Reset SHALL immediately force IDLE, all corner outputs 0, corners_valid 0, update_pulse 0, marker_count 0, and clear accumulators, including mid-SCAN or mid-UPDATE.
REQ-022 First frame_start after reset deassertion SHALL be honoured; no spurious update_pulse.

Verification
REQ-023 Reset pulse mid-operation -> all outputs 0, corners_valid 0, no update_pulse until a full frame completes.
REQ-024 Frame with markers x=100..109, y=50..59 (100 px) -> TL (100,50), TR (109,50), BL (100,59), BR (109,59); corners_valid 1; marker_count 100; update_pulse one cycle, one cycle after frame_end.
REQ-025 Next frame, same square shifted to x=108..117 -> top_left_x=102, top_right_x=111, y unchanged (shift 2).
REQ-026 Frame with 10 marker pixels -> corners held, corners_valid 0, marker_count 10, update_pulse 1; following 100-px frame loads raw corners.
REQ-027 frame_start mid-SCAN after 50 markers at (5,5), then 100-px square -> corners equal square only; marker_count 100.
REQ-028 Markers at x=700 or y=500 plus valid square -> out-of-range pixels excluded from count and corners.
